// File: rtl/bcd_convert_seq_pkg.sv
// bcd_convert_seq_pkg: shared constants, FSM states and count-width helper for the BCD converter
package bcd_convert_seq_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD = 4'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD digit field of 5 or more
module bcd_digit_adj
    import bcd_convert_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);
    assign adjusted = (digit >= ADJ_THRESHOLD) ? digit + ADJ_ADD : digit;
endmodule

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
module bcd_convert_seq
    import bcd_convert_seq_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET,
    input  logic                          start,
    input  logic [BIN_WIDTH-1:0]          bin,
    output logic                          ready,
    output logic                          valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);
    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int SW = BW + BIN_WIDTH;
    localparam int CW = cnt_w(BIN_WIDTH);

    state_t state, state_nx;
    logic [SW-1:0] sr, adj;
    logic [CW-1:0] count;
    logic acc;
    logic last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit   (sr[BIN_WIDTH+BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .adjusted(adj[BIN_WIDTH+BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end
    assign adj[BIN_WIDTH-1:0] = sr[BIN_WIDTH-1:0];

    assign ready = state != SHIFT;
    assign valid = state == DONE;
    assign last  = count == CW'(1);

    always_comb begin
        state_nx = state;
        case (state)
            SHIFT:   state_nx = last ? DONE : SHIFT;
            default: state_nx = start ? SHIFT : IDLE;
        endcase
    end

    // Results latch on the final shift edge so bcd is already correct while valid is high
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            sr       <= '0;
            count    <= '0;
            acc      <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (ready && start) begin
                sr    <= {{BW{1'b0}}, bin};
                acc   <= 1'b0;
                count <= CW'(BIN_WIDTH);
            end else if (state == SHIFT) begin
                sr    <= {adj[SW-2:0], 1'b0};
                acc   <= acc | adj[SW-1];
                count <= count - 1'b1;
                if (last) begin
                    bcd      <= adj[SW-2 -: BW];
                    overflow <= acc | adj[SW-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb_bcd_convert_seq: randomized and directed checks of both a 3-digit and a 2-digit converter against a behavioural model
module tb_bcd_convert_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] bin = '0;
    logic ready3, valid3, ovf3, ready2, valid2, ovf2;
    logic [11:0] bcd3;
    logic [7:0] bcd2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_convert_seq #(.BIN_WIDTH(W), .DIGITS(3)) dut3 (
        .CLOCK_50(clk), .RESET(rst), .start(start), .bin(bin),
        .ready(ready3), .valid(valid3), .bcd(bcd3), .overflow(ovf3)
    );

    bcd_convert_seq #(.BIN_WIDTH(W), .DIGITS(2)) dut2 (
        .CLOCK_50(clk), .RESET(rst), .start(start), .bin(bin),
        .ready(ready2), .valid(valid2), .bcd(bcd2), .overflow(ovf2)
    );

    function automatic logic [11:0] to_bcd(input int v, input int d);
        logic [11:0] r = '0;
        int x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: p = 0 idle, 1..W busy shifting, W+1 result cycle
    int p = 0;
    logic [W-1:0] mbin = '0;
    logic [11:0] m_bcd3 = '0;
    logic [7:0] m_bcd2 = '0;
    logic m_ovf3 = 1'b0, m_ovf2 = 1'b0;
    logic m_ready, m_valid;
    assign m_ready = (p == 0) || (p == W + 1);
    assign m_valid = p == W + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p = 0;
            m_bcd3 = '0;
            m_bcd2 = '0;
            m_ovf3 = 1'b0;
            m_ovf2 = 1'b0;
        end else if (p >= 1 && p < W) begin
            p++;
        end else if (p == W) begin
            p = W + 1;
            m_bcd3 = to_bcd(int'(mbin) % 1000, 3);
            m_ovf3 = int'(mbin) >= 1000;
            m_bcd2 = 8'(to_bcd(int'(mbin) % 100, 2));
            m_ovf2 = int'(mbin) >= 100;
        end else if (start) begin
            p = 1;
            mbin = bin;
        end else begin
            p = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("ready3", 32'(ready3), 32'(m_ready));
        chk("valid3", 32'(valid3), 32'(m_valid));
        chk("bcd3", 32'(bcd3), 32'(m_bcd3));
        chk("ovf3", 32'(ovf3), 32'(m_ovf3));
        chk("ready2", 32'(ready2), 32'(m_ready));
        chk("valid2", 32'(valid2), 32'(m_valid));
        chk("bcd2", 32'(bcd2), 32'(m_bcd2));
        chk("ovf2", 32'(ovf2), 32'(m_ovf2));
    end

    task automatic wait_ready();
        int k = 0;
        while (!m_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) chk("ready_timeout", 32'(0), 32'(1));
    endtask

    task automatic conv(input logic [W-1:0] b);
        wait_ready();
        start = 1'b1;
        bin = b;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 1) @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [W-1:0] b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready3), 32'(1));
        chk("rst_valid", 32'(valid3), 32'(0));
        chk("rst_bcd", 32'(bcd3), 32'(0));
        chk("rst_ovf", 32'(ovf3), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        start = 1'b1;
        bin = '0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (valid3) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(9));
        chk("zero_bcd", 32'(bcd3), 32'(12'h000));
        @(negedge clk);

        conv(8'd255); chk("bcd_255", 32'(bcd3), 32'(12'h255)); chk("ovf_255", 32'(ovf3), 32'(0));
        conv(8'd99);  chk("bcd_99", 32'(bcd3), 32'(12'h099));
        conv(8'd100); chk("bcd_100", 32'(bcd3), 32'(12'h100));
        conv(8'd200); chk("d2_bcd_200", 32'(bcd2), 32'(8'h00)); chk("d2_ovf_200", 32'(ovf2), 32'(1));
        conv(8'd57);  chk("d2_bcd_57", 32'(bcd2), 32'(8'h57)); chk("d2_ovf_57", 32'(ovf2), 32'(0));

        for (int v = 0; v < 256; v++) conv(W'(v));

        // start noise while busy must not disturb the accepted value
        for (int t = 0; t < 5; t++) begin
            wait_ready();
            b0 = W'($urandom);
            start = 1'b1;
            bin = b0;
            @(negedge clk);
            for (int c = 0; c < W - 1; c++) begin
                start = 1'($urandom);
                bin = W'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
            repeat (3) @(negedge clk);
            chk("noise_bcd", 32'(bcd3), 32'(to_bcd(int'(b0), 3)));
        end

        start = 1'b1;
        for (int c = 0; c < 10 * (W + 1); c++) begin
            bin = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        conv(8'd0);
        start = 1'b1;
        bin = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_bcd", 32'(bcd3), 32'(0));
        chk("abort_ready", 32'(ready3), 32'(1));
        chk("abort_valid", 32'(valid3), 32'(0));
        rst = 1'b0;
        repeat (12) @(negedge clk);
        conv(8'd7);
        chk("bcd_7", 32'(bcd3), 32'(12'h007));

        for (int c = 0; c < 400; c++) begin
            start = ($urandom_range(0, 3) == 0);
            bin = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Sequential double-dabble binary-to-BCD converter.
- Sits directly upstream of the seven_segment digit decoders and replaces the combinational converter on the switch-to-display path.
- Accepts a binary word with a start/ready handshake and iterates one bit per clock.
- Presents a held packed-BCD result (ones digit in the low nibble) with a one-cycle valid pulse and an overflow flag.

Parameters:
- BIN_WIDTH, 8, width of the binary input in bits (>=1).
- DIGITS, 3, number of BCD output digits (>=1).

Ports:
- CLOCK_50  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; accepted only while ready=1.
- bin  input  BIN_WIDTH  binary value, sampled on the accepting edge only.
- ready  output  1  high when a start will be accepted.
- valid  output  1  one-cycle pulse when bcd/overflow update.
- bcd  output  4*DIGITS  packed BCD result, held until the next completion.
- overflow  output  1  result did not fit in DIGITS digits; held with bcd.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: ready=1, valid=0, bcd=0, overflow=0, state IDLE, shift counter 0.
- States:
  - IDLE: ready=1. On start=1, load a shift register of DIGITS*4 zero bits followed by bin, clear the overflow accumulator, set count=BIN_WIDTH, go to SHIFT.
  - SHIFT: ready=0. Each cycle:
    - Adjust every digit field: if >=5, add 3 (4-bit result).
    - Shift the whole register left by 1.
    - If the bit shifted out of the top digit is 1, set the overflow accumulator.
    - Decrement count. On the cycle count reaches 0, go to DONE.
  - DONE: lasts one cycle. bcd <= digit field, overflow <= accumulator, valid=1, ready=1. On start=1 in this cycle, immediately load the new bin and go to SHIFT; otherwise go to IDLE.
- Latency: if start is accepted at edge E, valid is high in the cycle following edge E+BIN_WIDTH, i.e. exactly BIN_WIDTH+1 cycles after the accepting cycle.
- Throughput: one result per BIN_WIDTH+1 cycles with back-to-back starts.
- start while ready=0 is ignored; no queueing. Changes on bin while busy have no effect.
- valid is high for exactly one cycle per accepted start, never otherwise.
- bcd and overflow change only in the DONE transition; they hold through IDLE and SHIFT, so displays never show partial values.
- Overflow:
  - Defaults (8 bits, 3 digits, max 255) never overflow.
  - When overflow=1, bcd equals bin mod 10^DIGITS.
- Arithmetic: digit adjust is unsigned 4-bit; no digit ever exceeds 9 after the final shift.
- RESET asserted mid-conversion aborts it immediately: no valid pulse, bcd returns to 0, ready=1 on the first clock after release.
- The count register is sized to hold BIN_WIDTH (clog2(BIN_WIDTH+1) bits).

Decomposition:
- Shared package:
  - BCD_DIGIT_W=4 and ADJ_THRESHOLD=5.
  - ADJ_ADD=3.
  - State enum {IDLE, SHIFT, DONE}.
  - A width function for the count register.
- One combinational sub-module, bcd_digit_adj (4-bit in, 4-bit out, add 3 if >=5). Instantiated DIGITS times in a generate loop.
- Counter, FSM and output registers stay in bcd_convert_seq.

Test Plan:
- Defaults, reset release, start=1 with bin=0 for one cycle -> ready drops next cycle; valid pulses exactly 9 cycles after the accept cycle; bcd=12'h000, overflow=0.
- bin=255 -> bcd=12'h255, overflow=0. bin=99 -> 12'h099. bin=100 -> 12'h100. Then exhaustively sweep 0..255 against a reference model.
- start pulsed repeatedly during SHIFT with changing bin -> ignored; single valid; result matches the originally accepted value.
- start held high continuously with bin changing each result -> valid every 9 cycles, each bcd matching the bin sampled on its accepting edge.
- RESET asserted at the 4th SHIFT cycle of bin=200 -> bcd=0, valid never pulses, ready=1 after release; the next conversion of 7 gives 12'h007.
- DIGITS=2, bin=200 -> bcd=8'h00, overflow=1. bin=57 -> bcd=8'h57, overflow=0.
